// File: rtl/fibo_pkg.sv
// fibo_pkg: shared states and widths for the Fibonacci scheduler slice.
package fibo_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} fsched_state_t;
    localparam int FIBO_IDX_W = 5;
    localparam int FIBO_DATA_W = 16;
    localparam logic [FIBO_IDX_W-1:0] FIBO_OVF_N = 5'd25;
endpackage

// File: rtl/fibo_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant among req, searching from a rotating pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int W = $clog2(N);
    logic [W-1:0] ptr, idx;
    // Walk offsets from far to near so the closest request to ptr wins.
    always_comb begin
        idx = '0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + W'(k);
            if (req[idx]) grant_idx = idx;
        end
        grant = |req ? (N'(1) << grant_idx) : '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ptr <= '0;
        else if (advance) ptr <= grant_idx + W'(1);
endmodule

// File: rtl/fibo_scheduler.sv
// fibo_scheduler: shares one Fibonacci calculator among N_REQ requesters,
// one request in flight, index 0 answered directly without the calculator.
module fibo_scheduler
    import fibo_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*FIBO_IDX_W-1:0]  req_n,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [FIBO_DATA_W-1:0]       rsp_data,
    output logic                         rsp_ovf,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic                         calc_begin,
    output logic [FIBO_IDX_W-1:0]        calc_s,
    input  logic                         calc_done,
    input  logic [FIBO_DATA_W-1:0]       calc_out
);
    localparam int GW = $clog2(N_REQ);
    fsched_state_t state, state_nx;
    logic [N_REQ-1:0] grant;
    logic [GW-1:0] gidx, g_q;
    logic [FIBO_IDX_W-1:0] n_sel, n_q;
    logic [FIBO_DATA_W-1:0] data_q;
    logic ovf_q, idle, any;

    assign idle = state == IDLE;
    assign any = idle && |req_valid;
    assign n_sel = req_n[gidx*FIBO_IDX_W +: FIBO_IDX_W];

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (idle ? req_valid : '0),
        .advance  (any),
        .grant    (grant),
        .grant_idx(gidx)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = any ? (n_sel == '0 ? RESPOND : LAUNCH) : IDLE;
            LAUNCH:  state_nx = WAIT;
            WAIT:    state_nx = calc_done ? RESPOND : WAIT;
            RESPOND: state_nx = rsp_ready[g_q] ? IDLE : RESPOND;
            default: state_nx = IDLE;
        endcase
    end

    // Capture is cleared at grant, so the n==0 bypass answers with data 0.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            g_q <= '0;
            n_q <= '0;
            data_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (any) begin
                g_q <= gidx;
                n_q <= n_sel;
                data_q <= '0;
                ovf_q <= 1'b0;
            end
            if (state == WAIT && calc_done) begin
                data_q <= calc_out;
                ovf_q <= n_q >= FIBO_OVF_N;
            end
        end

    assign req_ready = grant;
    assign rsp_valid = (state == RESPOND) ? (N_REQ'(1) << g_q) : '0;
    assign rsp_data = data_q;
    assign rsp_ovf = ovf_q;
    assign calc_begin = state == LAUNCH;
    assign calc_s = calc_begin ? n_q : '0;
endmodule

// File: tb/tb_fibo_scheduler.sv
// tb_fibo_scheduler: directed tests plus a per-cycle latency-rule model,
// with a behavioural calculator answering the begin/done protocol.
module tb_fibo_scheduler;
    localparam int N = 4;
    logic clk = 1'b0, reset_n;
    logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*5-1:0] req_n;
    logic [15:0] rsp_data, calc_out;
    logic rsp_ovf, calc_begin, calc_done;
    logic [4:0] calc_s;
    int n_cmp = 0, n_err = 0, cyc = 0, n_begin = 0, tg, tr;

    fibo_scheduler #(.N_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_n(req_n),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready), .calc_begin(calc_begin),
        .calc_s(calc_s), .calc_done(calc_done), .calc_out(calc_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (reset_n && calc_begin) n_begin <= n_begin + 1;

    function automatic logic [15:0] fib(input int n);
        logic [15:0] a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Calculator: done is a level once the count reaches 1 and stays there.
    logic [4:0] c_cnt;
    logic [15:0] c_out;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            c_cnt <= 0;
            c_out <= 0;
        end else if (calc_begin) begin
            c_cnt <= calc_s;
            c_out <= fib(int'(calc_s));
        end else if (c_cnt > 1) c_cnt <= c_cnt - 1;
    assign calc_done = c_cnt == 1;
    assign calc_out = c_out;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Model: grant cycle is age 0; begin at age 1; response at age n+2 (n==0: age 1).
    bit m_busy = 0;
    int m_ptr = 0, m_g = 0, m_n = 0, m_age = 0;
    always @(negedge clk) begin
        int g, lat, e_rr, e_rv, e_b, e_s;
        if (!reset_n) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_calc_begin", int'(calc_begin), 0);
            chk("rst_calc_s", int'(calc_s), 0);
            chk("rst_rsp_data", int'(rsp_data), 0);
            chk("rst_rsp_ovf", int'(rsp_ovf), 0);
            m_busy = 0;
            m_ptr = 0;
        end else begin
            g = -1; e_rr = 0; e_rv = 0; e_b = 0; e_s = 0;
            if (!m_busy) begin
                for (int k = N - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                if (g >= 0) e_rr = 1 << g;
            end else begin
                lat = (m_n == 0) ? 1 : m_n + 2;
                if (m_n != 0 && m_age == 1) begin
                    e_b = 1;
                    e_s = m_n;
                end
                if (m_age >= lat) e_rv = 1 << m_g;
            end
            chk("req_ready", int'(req_ready), e_rr);
            chk("rsp_valid", int'(rsp_valid), e_rv);
            chk("calc_begin", int'(calc_begin), e_b);
            chk("calc_s", int'(calc_s), e_s);
            if (e_rv != 0) begin
                chk("rsp_data", int'(rsp_data), int'(fib(m_n)));
                chk("rsp_ovf", int'(rsp_ovf), int'(m_n >= 25));
            end
            if (!m_busy && g >= 0) begin
                m_busy = 1;
                m_g = g;
                m_n = int'(req_n[g*5 +: 5]);
                m_age = 1;
                m_ptr = (g + 1) % N;
            end else if (m_busy) begin
                if (e_rv != 0 && rsp_ready[m_g]) m_busy = 0;
                else m_age++;
            end
        end
    end

    task automatic wait_grant(output int g);
        int k = 0;
        @(negedge clk);
        while (req_ready == '0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tg = cyc;
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        if (g < 0) timeout("grant_wait");
    endtask

    task automatic wait_rsp(input int i);
        int k = 0;
        @(negedge clk);
        while (!rsp_valid[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        tr = cyc;
        if (!rsp_valid[i]) timeout("rsp_wait");
    endtask

    task automatic drive(input int i, input int n);
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_n[i*5 +: 5] = 5'(n);
    endtask

    task automatic drop(input int i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic ack(input int i);
        @(posedge clk); #1;
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
    endtask

    task automatic single(input int i, input int n, input int lat, input int data, input int ovf);
        int g;
        drive(i, n);
        wait_grant(g);
        chk("grant_idx", g, i);
        drop(i);
        wait_rsp(i);
        chk("latency", tr - tg, lat);
        chk("data", int'(rsp_data), data);
        chk("ovf", int'(rsp_ovf), ovf);
        ack(i);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int g, nb, r;
        int exp4[4] = '{2, 3, 5, 8};
        reset_n = 1'b0;
        req_valid = '0;
        req_n = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({req_ready, rsp_valid, calc_begin, rsp_ovf}), 0);
        chk("reset_data", int'(rsp_data), 0);
        reset_n = 1'b1;

        single(2, 10, 12, 55, 0);
        nb = n_begin;
        single(0, 0, 1, 0, 0);
        chk("bypass_no_begin", n_begin, nb);
        single(1, 25, 27, 9489, 1);
        single(2, 24, 26, 46368, 0);
        single(3, 1, 3, 1, 0);

        @(posedge clk); #1;
        req_valid = '1;
        req_n = {5'd6, 5'd5, 5'd4, 5'd3};
        for (int j = 0; j < 4; j++) begin
            wait_grant(g);
            chk("rr_order", g, j);
            drop(g);
            wait_rsp(g);
            chk("rr_data", int'(rsp_data), exp4[j]);
            ack(g);
        end

        @(posedge clk); #1;
        req_valid = 4'b1010;
        req_n = {5'd7, 5'd0, 5'd6, 5'd0};
        wait_grant(g);
        chk("rereq_first", g, 1);
        drop(1);
        wait_rsp(1);
        chk("rereq_data1", int'(rsp_data), 8);
        ack(1);
        wait_grant(g);
        chk("rereq_second", g, 3);
        drop(3);
        wait_rsp(3);
        chk("rereq_data3", int'(rsp_data), 13);
        ack(3);

        drive(1, 5);
        wait_grant(g);
        drop(1);
        wait_rsp(1);
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        req_n[10 +: 5] = 5'd3;
        rsp_ready = 4'b1101;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(rsp_valid), 2);
            chk("bp_data", int'(rsp_data), 5);
            chk("bp_no_grant", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 4'b0010;
        r = cyc;
        @(posedge clk); #1;
        rsp_ready = '0;
        wait_grant(g);
        chk("bp_next_grant", g, 2);
        chk("bp_grant_gap", tg - r, 1);
        drop(2);
        wait_rsp(2);
        chk("bp_next_data", int'(rsp_data), 2);
        ack(2);

        drive(0, 20);
        wait_grant(g);
        drop(0);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midwait_rst_out", int'({req_ready, rsp_valid, calc_begin, calc_s, rsp_ovf}), 0);
        chk("midwait_rst_data", int'(rsp_data), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0011;
        req_n = {5'd0, 5'd0, 5'd2, 5'd7};
        wait_grant(g);
        chk("post_rst_ptr", g, 0);
        drop(0);
        wait_rsp(0);
        chk("post_rst_lat", tr - tg, 9);
        chk("post_rst_data", int'(rsp_data), 13);
        ack(0);
        wait_grant(g);
        chk("post_rst_next", g, 1);
        drop(1);
        wait_rsp(1);
        chk("post_rst_data2", int'(rsp_data), 1);
        ack(1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
